csi_dphy_hs_rx_ctrl: RTL and testbench
======================================

CSI_DPHY_HS_RX_CTRL -- requirements
Module: csi_dphy_hs_rx_ctrl

Interface
REQ-001 Parameter NUM_LANES, default 2, sets the number of data lanes controlled (1..4).
REQ-002 Parameter TERM_EN_CYC, default 2, sets the cycles from LP-00 entry to HS enable.
REQ-003 Parameter SETTLE_CYC, default 8, sets the HS settle cycles before sync hunting.
REQ-004 Parameter SYNC_TIMEOUT, default 32, sets the maximum hunt cycles before sync error.
REQ-005 Port list (name, direction, width, meaning):
- cam_ck_CLKOUT  in  1  byte clock.
- rstn  in  1  reset, asynchronous, active-low.
- enable  in  1  software enable, synchronous to cam_ck_CLKOUT.
- lp_p  in  NUM_LANES  LP+ level per lane, already double-synchronized.
- lp_n  in  NUM_LANES  LP- level per lane, already double-synchronized.
- hs_data  in  8*NUM_LANES  HS byte from each lane FIFO, lane 0 in [7:0].
- fifo_empty  in  NUM_LANES  lane FIFO empty.
- hs_term  out  NUM_LANES  HS termination enable.
- hs_ena  out  NUM_LANES  HS receiver enable.
- fifo_rd  out  NUM_LANES  lane FIFO read strobe.
- byte_data  out  8*NUM_LANES  aligned payload bytes.
- byte_valid  out  NUM_LANES  payload byte qualifier.
- sync_err  out  NUM_LANES  one-cycle sync-timeout pulse.
- all_lanes_hs  out  1  high while every lane is in HS_DATA.

Function
REQ-006 Each lane SHALL run an independent FSM with states STOP, HS_RQST, BRIDGE, TERM, SETTLE, HUNT, HS_DATA and WAIT_STOP.
REQ-007 In STOP, LP=01 SHALL move the FSM to HS_RQST; any other LP value SHALL hold STOP.
REQ-008 In HS_RQST, LP=00 SHALL move the FSM to BRIDGE, LP=11 SHALL return it to STOP, and LP=10 SHALL move it to WAIT_STOP.
REQ-009 BRIDGE SHALL last exactly one cycle and then enter TERM; LP=11 sampled in BRIDGE SHALL instead return the FSM to STOP.
REQ-010 In TERM, hs_term SHALL be 1 and a counter SHALL run for TERM_EN_CYC cycles, after which the FSM enters SETTLE.
REQ-011 In SETTLE, hs_term and hs_ena SHALL both be 1 and the FSM SHALL remain for SETTLE_CYC cycles, then enter HUNT.
REQ-012 In HUNT and HS_DATA, fifo_rd SHALL equal ~fifo_empty for that lane.
REQ-013 In HUNT, the FSM SHALL enter HS_DATA when a read byte equals 8'hB8; that sync byte SHALL NOT be forwarded.
REQ-014 If HUNT lasts SYNC_TIMEOUT cycles without a sync byte, sync_err SHALL pulse for one cycle and the FSM SHALL enter WAIT_STOP.
REQ-015 In HS_DATA, byte_valid SHALL be asserted in the cycle after each fifo_rd accepted while the FIFO was non-empty, with byte_data carrying hs_data registered at that read (1-cycle latency).
REQ-016 LP=11 sampled in TERM, SETTLE, HUNT or HS_DATA SHALL return the FSM to STOP on the next cycle with hs_term, hs_ena and fifo_rd low.
REQ-017 An in-flight byte read in the cycle LP=11 is sampled SHALL still be presented on byte_valid.
REQ-018 WAIT_STOP SHALL hold all lane outputs low until LP=11 is sampled, then enter STOP.
REQ-019 When enable is 0, every lane SHALL be forced to STOP on the next cycle with all outputs low.
REQ-020 Counters SHALL be sized with $clog2 of max(TERM_EN_CYC, SETTLE_CYC, SYNC_TIMEOUT)+1 and SHALL saturate, never wrapping.
REQ-021 all_lanes_hs SHALL be the registered AND of the per-lane HS_DATA flags.

Reset
REQ-022 On rstn low, every FSM SHALL be in STOP, all counters SHALL be 0, and hs_term, hs_ena, fifo_rd, byte_valid, sync_err and all_lanes_hs SHALL be 0.
REQ-023 On rstn low, byte_data SHALL be 0.
REQ-024 Reset asserted mid-HS SHALL take effect immediately, and after release the lane SHALL require a full LP-11 to LP-01 to LP-00 entry again.

Structure
REQ-025 The state enum, the SYNC_BYTE constant 8'hB8 and the LP code constants SHALL live in the shared package csi_dphy_pkg.
REQ-026 The per-lane FSM, counter and byte register SHALL be the sub-module csi_dphy_lane_fsm, instantiated NUM_LANES times by generate.

Verification
REQ-027 Nominal entry: LP 11, 01, 00, then B8 followed by 12 34 -> hs_term rises 2 cycles after LP-00, hs_ena rises 2 cycles later, byte_valid emits 12 then 34, and all_lanes_hs=1.
REQ-028 Sync timeout: after entry, 32 cycles of byte 00 -> sync_err pulses once, the lane holds in WAIT_STOP, and recovery occurs only after LP-11.
REQ-029 Aborted request: LP 11, 01, 11 -> hs_term is never asserted and the FSM is back in STOP.
REQ-030 FIFO starvation: fifo_empty toggled every other cycle in HS_DATA -> byte_valid is asserted only for the reads that succeeded, and no bytes are duplicated or lost.
REQ-031 Mid-packet abort: enable dropped while in HS_DATA, then separately rstn pulsed while in HS_DATA -> all outputs are 0 the next cycle (enable case) or immediately (reset case).
REQ-032 Lane skew: lane 1 sync arrives 3 cycles after lane 0 -> all_lanes_hs rises only after lane 1 enters HS_DATA.

Source files
------------

// File: rtl/csi_dphy_pkg.sv
// Shared types and constants for the CSI-2 D-PHY HS receive controller.
// Lane FSM states, the HS sync byte and the {LP+, LP-} line codes.
package csi_dphy_pkg;

   typedef enum logic [2:0] {
      ST_STOP,
      ST_HS_RQST,
      ST_BRIDGE,
      ST_TERM,
      ST_SETTLE,
      ST_HUNT,
      ST_HS_DATA,
      ST_WAIT_STOP
   } lane_st_e;

   localparam logic [7:0] SYNC_BYTE = 8'hB8;

   // LP codes are {lp_p, lp_n}
   localparam logic [1:0] LP_00 = 2'b00;
   localparam logic [1:0] LP_01 = 2'b01;
   localparam logic [1:0] LP_10 = 2'b10;
   localparam logic [1:0] LP_11 = 2'b11;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/csi_dphy_lane_fsm.sv
// Per-lane D-PHY HS entry FSM: LP handshake, termination/settle timing,
// sync-byte hunt and registered payload byte forwarding.
module csi_dphy_lane_fsm
   import csi_dphy_pkg::*;
#(
   parameter int TERM_EN_CYC  = 2,
   parameter int SETTLE_CYC   = 8,
   parameter int SYNC_TIMEOUT = 32
) (
   input  logic       cam_ck_CLKOUT,
   input  logic       rstn,
   input  logic       enable_i,
   input  logic       lp_p_i,
   input  logic       lp_n_i,
   input  logic [7:0] hs_data_i,
   input  logic       fifo_empty_i,
   output logic       hs_term_o,
   output logic       hs_ena_o,
   output logic       fifo_rd_o,
   output logic [7:0] byte_data_o,
   output logic       byte_valid_o,
   output logic       sync_err_o,
   output logic       in_hs_o
);

   localparam int CMAX = max3(TERM_EN_CYC, SETTLE_CYC, SYNC_TIMEOUT);
   localparam int CW   = $clog2(CMAX + 1);
   localparam logic [CW-1:0] CSAT      = CW'(CMAX);
   localparam logic [CW-1:0] TERM_LAST = CW'(TERM_EN_CYC - 1);
   localparam logic [CW-1:0] SETL_LAST = CW'(SETTLE_CYC - 1);
   localparam logic [CW-1:0] HUNT_LAST = CW'(SYNC_TIMEOUT - 1);

   lane_st_e      st_q, st_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic [7:0]    bd_q, bd_d;
   logic          bv_q, bv_d;
   logic [1:0]    lp;
   logic          rd, accept;

   assign lp      = {lp_p_i, lp_n_i};
   assign cnt_inc = (cnt_q == CSAT) ? cnt_q : cnt_q + 1'b1;

   always_comb begin
      st_d       = st_q;
      hs_term_o  = 1'b0;
      hs_ena_o   = 1'b0;
      rd         = 1'b0;
      sync_err_o = 1'b0;
      case (st_q)
         ST_STOP:    if (lp == LP_01) st_d = ST_HS_RQST;
         ST_HS_RQST: begin
            case (lp)
               LP_00:   st_d = ST_BRIDGE;
               LP_11:   st_d = ST_STOP;
               LP_10:   st_d = ST_WAIT_STOP;
               default: st_d = ST_HS_RQST;
            endcase
         end
         ST_BRIDGE:  st_d = (lp == LP_11) ? ST_STOP : ST_TERM;
         ST_TERM: begin
            hs_term_o = 1'b1;
            if (lp == LP_11)             st_d = ST_STOP;
            else if (cnt_q == TERM_LAST) st_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            hs_term_o = 1'b1;
            hs_ena_o  = 1'b1;
            if (lp == LP_11)             st_d = ST_STOP;
            else if (cnt_q == SETL_LAST) st_d = ST_HUNT;
         end
         ST_HUNT: begin
            hs_term_o = 1'b1;
            hs_ena_o  = 1'b1;
            rd        = ~fifo_empty_i;
            if (lp == LP_11)                        st_d = ST_STOP;
            else if (rd && hs_data_i == SYNC_BYTE)  st_d = ST_HS_DATA;
            else if (cnt_q == HUNT_LAST) begin
               sync_err_o = 1'b1;
               st_d       = ST_WAIT_STOP;
            end
         end
         ST_HS_DATA: begin
            hs_term_o = 1'b1;
            hs_ena_o  = 1'b1;
            rd        = ~fifo_empty_i;
            if (lp == LP_11) st_d = ST_STOP;
         end
         ST_WAIT_STOP: if (lp == LP_11) st_d = ST_STOP;
         default:    st_d = ST_STOP;
      endcase
      // Disabling stops FIFO pops at once so no byte is drained and dropped
      if (!enable_i) begin
         st_d       = ST_STOP;
         rd         = 1'b0;
         sync_err_o = 1'b0;
      end
   end

   assign accept = rd && (st_q == ST_HS_DATA);
   assign bv_d   = accept;
   assign bd_d   = accept ? hs_data_i : 8'h00;
   assign cnt_d  = ((st_d == st_q) && (st_q inside {ST_TERM, ST_SETTLE, ST_HUNT}))
                   ? cnt_inc : '0;

   always_ff @(posedge cam_ck_CLKOUT or negedge rstn) begin
      if (!rstn) begin
         st_q  <= ST_STOP;
         cnt_q <= '0;
         bv_q  <= 1'b0;
         bd_q  <= 8'h00;
      end else begin
         st_q  <= st_d;
         cnt_q <= cnt_d;
         bv_q  <= bv_d;
         bd_q  <= bd_d;
      end
   end

   assign fifo_rd_o    = rd;
   assign byte_valid_o = bv_q;
   assign byte_data_o  = bd_q;
   assign in_hs_o      = (st_q == ST_HS_DATA);

endmodule

// File: rtl/csi_dphy_hs_rx_ctrl.sv
// D-PHY HS receive controller: one independent entry FSM per data lane
// plus a registered all-lanes-in-HS indication.
module csi_dphy_hs_rx_ctrl
   import csi_dphy_pkg::*;
#(
   parameter int NUM_LANES    = 2,
   parameter int TERM_EN_CYC  = 2,
   parameter int SETTLE_CYC   = 8,
   parameter int SYNC_TIMEOUT = 32
) (
   input  logic                   cam_ck_CLKOUT,
   input  logic                   rstn,
   input  logic                   enable,
   input  logic [NUM_LANES-1:0]   lp_p,
   input  logic [NUM_LANES-1:0]   lp_n,
   input  logic [8*NUM_LANES-1:0] hs_data,
   input  logic [NUM_LANES-1:0]   fifo_empty,
   output logic [NUM_LANES-1:0]   hs_term,
   output logic [NUM_LANES-1:0]   hs_ena,
   output logic [NUM_LANES-1:0]   fifo_rd,
   output logic [8*NUM_LANES-1:0] byte_data,
   output logic [NUM_LANES-1:0]   byte_valid,
   output logic [NUM_LANES-1:0]   sync_err,
   output logic                   all_lanes_hs
);

   logic [NUM_LANES-1:0] in_hs;
   logic                 all_hs_q, all_hs_d;

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      csi_dphy_lane_fsm #(
         .TERM_EN_CYC  (TERM_EN_CYC),
         .SETTLE_CYC   (SETTLE_CYC),
         .SYNC_TIMEOUT (SYNC_TIMEOUT)
      ) u_lane (
         .cam_ck_CLKOUT (cam_ck_CLKOUT),
         .rstn          (rstn),
         .enable_i      (enable),
         .lp_p_i        (lp_p[g]),
         .lp_n_i        (lp_n[g]),
         .hs_data_i     (hs_data[8*g +: 8]),
         .fifo_empty_i  (fifo_empty[g]),
         .hs_term_o     (hs_term[g]),
         .hs_ena_o      (hs_ena[g]),
         .fifo_rd_o     (fifo_rd[g]),
         .byte_data_o   (byte_data[8*g +: 8]),
         .byte_valid_o  (byte_valid[g]),
         .sync_err_o    (sync_err[g]),
         .in_hs_o       (in_hs[g])
      );
   end

   // Gated by enable so the flag clears together with the lanes
   assign all_hs_d = enable & (&in_hs);

   always_ff @(posedge cam_ck_CLKOUT or negedge rstn) begin
      if (!rstn) all_hs_q <= 1'b0;
      else       all_hs_q <= all_hs_d;
   end

   assign all_lanes_hs = all_hs_q;

endmodule

// File: tb/tb_csi_dphy_hs_rx_ctrl.sv
// Directed bench for csi_dphy_hs_rx_ctrl (2 lanes, default timing):
// vector table for the nominal HS session plus hand-written corner sequences.
module tb_csi_dphy_hs_rx_ctrl;

   logic        clk = 1'b0;
   logic        rstn;
   logic        en;
   logic [1:0]  lpp, lpn, fe;
   logic [15:0] hsd;
   logic [1:0]  term, ena, rd, bv, serr;
   logic [15:0] bd;
   logic        all_hs;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   csi_dphy_hs_rx_ctrl #(
      .NUM_LANES(2), .TERM_EN_CYC(2), .SETTLE_CYC(8), .SYNC_TIMEOUT(32)
   ) dut (
      .cam_ck_CLKOUT (clk),
      .rstn          (rstn),
      .enable        (en),
      .lp_p          (lpp),
      .lp_n          (lpn),
      .hs_data       (hsd),
      .fifo_empty    (fe),
      .hs_term       (term),
      .hs_ena        (ena),
      .fifo_rd       (rd),
      .byte_data     (bd),
      .byte_valid    (bv),
      .sync_err      (serr),
      .all_lanes_hs  (all_hs)
   );

   typedef struct {
      logic [1:0]  p, n;
      logic [15:0] d;
      logic [1:0]  f;
      logic        e;
      logic [1:0]  t, a, r, v;
      logic [15:0] b;
      logic        al;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(input logic [1:0] p, input logic [1:0] n,
                               input logic [15:0] d, input logic [1:0] f,
                               input logic e, input logic [1:0] t,
                               input logic [1:0] a, input logic [1:0] r,
                               input logic [1:0] v, input logic [15:0] b,
                               input logic al);
      vec_t x;
      x.p = p; x.n = n; x.d = d; x.f = f; x.e = e;
      x.t = t; x.a = a; x.r = r; x.v = v; x.b = b; x.al = al;
      return x;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Apply inputs for one cycle, leaving time to sample before the next edge
   task automatic drv(input logic [1:0] p, input logic [1:0] n,
                      input logic [15:0] d, input logic [1:0] f);
      @(negedge clk);
      lpp = p; lpn = n; hsd = d; fe = f;
      #1;
   endtask

   // Full LP-11 -> LP-01 -> LP-00 entry; next drv call lands in HUNT
   task automatic enter(input string tag);
      drv(2'b11, 2'b11, 16'h0, 2'b11);
      drv(2'b00, 2'b11, 16'h0, 2'b11);
      drv(2'b00, 2'b00, 16'h0, 2'b11);
      drv(2'b00, 2'b00, 16'h0, 2'b11);
      chk({tag, ".bridge_term"}, term, 2'b00);
      drv(2'b00, 2'b00, 16'h0, 2'b11);
      chk({tag, ".term_rise"}, {ena, term}, 4'b0011);
      drv(2'b00, 2'b00, 16'h0, 2'b11);
      drv(2'b00, 2'b00, 16'h0, 2'b11);
      chk({tag, ".ena_rise"}, {ena, term}, 4'b1111);
      repeat (7) drv(2'b00, 2'b00, 16'h0, 2'b11);
   endtask

   initial begin
      int first, pulses;
      logic [1:0] serr_seen, any;

      rstn = 1'b0; en = 1'b1; lpp = 2'b11; lpn = 2'b11; hsd = '0; fe = 2'b11;
      repeat (2) @(negedge clk);
      #1;
      chk("reset.outs", {term, ena, rd, bv, serr, all_hs}, 11'd0);
      chk("reset.byte_data", bd, 16'h0);
      @(negedge clk);
      rstn = 1'b1;

      // Nominal entry, starvation, LP-11 abort with in-flight byte, enable drop
      tv.push_back(mk(2'b11, 2'b11, 16'h0000, 2'b11, 1, 0, 0, 0, 0, 16'h0, 0));
      tv.push_back(mk(2'b00, 2'b11, 16'h0000, 2'b11, 1, 0, 0, 0, 0, 16'h0, 0));
      tv.push_back(mk(2'b00, 2'b00, 16'h0000, 2'b11, 1, 0, 0, 0, 0, 16'h0, 0));
      tv.push_back(mk(2'b00, 2'b00, 16'h0000, 2'b11, 1, 0, 0, 0, 0, 16'h0, 0));
      tv.push_back(mk(2'b00, 2'b00, 16'h0000, 2'b11, 1, 3, 0, 0, 0, 16'h0, 0));
      tv.push_back(mk(2'b00, 2'b00, 16'h0000, 2'b11, 1, 3, 0, 0, 0, 16'h0, 0));
      for (int i = 0; i < 8; i++)
         tv.push_back(mk(2'b00, 2'b00, 16'h0000, 2'b11, 1, 3, 3, 0, 0, 16'h0, 0));
      tv.push_back(mk(2'b00, 2'b00, 16'hB8B8, 2'b00, 1, 3, 3, 3, 0, 16'h0, 0));
      tv.push_back(mk(2'b00, 2'b00, 16'h5612, 2'b00, 1, 3, 3, 3, 0, 16'h0, 0));
      tv.push_back(mk(2'b00, 2'b00, 16'h7834, 2'b00, 1, 3, 3, 3, 3, 16'h5612, 1));
      tv.push_back(mk(2'b00, 2'b00, 16'h0000, 2'b11, 1, 3, 3, 0, 3, 16'h7834, 1));
      tv.push_back(mk(2'b00, 2'b00, 16'h0000, 2'b11, 1, 3, 3, 0, 0, 16'h0, 1));
      tv.push_back(mk(2'b00, 2'b00, 16'h2211, 2'b00, 1, 3, 3, 3, 0, 16'h0, 1));
      tv.push_back(mk(2'b00, 2'b00, 16'hFFFF, 2'b11, 1, 3, 3, 0, 3, 16'h2211, 1));
      tv.push_back(mk(2'b00, 2'b00, 16'h4433, 2'b00, 1, 3, 3, 3, 0, 16'h0, 1));
      tv.push_back(mk(2'b00, 2'b00, 16'hFFFF, 2'b11, 1, 3, 3, 0, 3, 16'h4433, 1));
      tv.push_back(mk(2'b00, 2'b00, 16'h0000, 2'b11, 1, 3, 3, 0, 0, 16'h0, 1));
      tv.push_back(mk(2'b01, 2'b01, 16'h6655, 2'b00, 1, 3, 3, 3, 0, 16'h0, 1));
      tv.push_back(mk(2'b01, 2'b01, 16'h0000, 2'b11, 1, 2, 2, 0, 3, 16'h6655, 1));
      tv.push_back(mk(2'b01, 2'b01, 16'h0000, 2'b11, 1, 2, 2, 0, 0, 16'h0, 0));
      tv.push_back(mk(2'b01, 2'b01, 16'h9988, 2'b00, 0, 2, 2, 0, 0, 16'h0, 0));
      tv.push_back(mk(2'b01, 2'b01, 16'h0000, 2'b11, 1, 0, 0, 0, 0, 16'h0, 0));
      tv.push_back(mk(2'b01, 2'b01, 16'hAAAA, 2'b00, 1, 0, 0, 0, 0, 16'h0, 0));

      for (int i = 0; i < tv.size(); i++) begin
         @(negedge clk);
         lpp = tv[i].p; lpn = tv[i].n; hsd = tv[i].d; fe = tv[i].f; en = tv[i].e;
         #1;
         chk($sformatf("v%0d.hs_term", i), term, tv[i].t);
         chk($sformatf("v%0d.hs_ena", i), ena, tv[i].a);
         chk($sformatf("v%0d.fifo_rd", i), rd, tv[i].r);
         chk($sformatf("v%0d.byte_valid", i), bv, tv[i].v);
         chk($sformatf("v%0d.byte_data", i), bd, tv[i].b);
         chk($sformatf("v%0d.sync_err", i), serr, 2'b00);
         chk($sformatf("v%0d.all_lanes_hs", i), all_hs, tv[i].al);
      end

      // Sync timeout: 32 hunt cycles of 00, then WAIT_STOP until LP-11
      enter("to_entry");
      first = -1; pulses = 0; serr_seen = '0;
      for (int i = 0; i < 40; i++) begin
         drv(2'b00, 2'b00, 16'h0000, 2'b00);
         if (serr != 2'b00) begin
            pulses++;
            if (first < 0) begin first = i; serr_seen = serr; end
         end
      end
      chk("timeout.first_cycle", first, 31);
      chk("timeout.pulse_count", pulses, 1);
      chk("timeout.lanes", serr_seen, 2'b11);
      chk("timeout.wait_outs", {term, ena, rd, bv}, 8'h00);
      drv(2'b00, 2'b11, 16'h0000, 2'b00);
      drv(2'b00, 2'b00, 16'h0000, 2'b00);
      drv(2'b00, 2'b00, 16'h0000, 2'b00);
      chk("timeout.lp01_ignored", {term, ena, rd}, 6'h00);
      enter("to_recover");

      // Aborted request: 11, 01, 11, then LP-00 must not start HS
      drv(2'b11, 2'b11, 16'h0, 2'b11);
      any = '0;
      drv(2'b11, 2'b11, 16'h0, 2'b11); any |= term;
      drv(2'b00, 2'b11, 16'h0, 2'b11); any |= term;
      drv(2'b11, 2'b11, 16'h0, 2'b11); any |= term;
      repeat (8) begin drv(2'b00, 2'b00, 16'h0, 2'b11); any |= term; end
      chk("abort_rqst.no_term", any, 2'b00);

      // Lane skew: lane 1 sync three cycles after lane 0
      enter("skew_entry");
      drv(2'b00, 2'b00, 16'h00B8, 2'b10);
      drv(2'b00, 2'b00, 16'h0000, 2'b11);
      chk("skew.h1_all", all_hs, 1'b0);
      drv(2'b00, 2'b00, 16'h0000, 2'b11);
      chk("skew.h2_all", all_hs, 1'b0);
      drv(2'b00, 2'b00, 16'hB800, 2'b01);
      chk("skew.h3_all", all_hs, 1'b0);
      drv(2'b00, 2'b00, 16'h0000, 2'b11);
      chk("skew.h4_all", all_hs, 1'b0);
      drv(2'b00, 2'b00, 16'h0000, 2'b11);
      chk("skew.h5_all", all_hs, 1'b1);

      // Reset asserted mid-HS clears everything without a clock edge
      drv(2'b00, 2'b00, 16'h1111, 2'b00);
      drv(2'b00, 2'b00, 16'h2222, 2'b00);
      chk("rst_mid.pre_bd", {bv, bd}, {2'b11, 16'h1111});
      rstn = 1'b0;
      #1;
      chk("rst_mid.outs", {term, ena, rd, bv, serr, all_hs}, 11'd0);
      chk("rst_mid.byte_data", bd, 16'h0);
      @(negedge clk);
      rstn = 1'b1;
      any = '0;
      repeat (20) begin drv(2'b00, 2'b00, 16'h0, 2'b00); any |= term | rd; end
      chk("rst_mid.needs_entry", any, 2'b00);
      enter("rst_reentry");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
